// File: rtl/axis_beam_splitter_if.sv
// AXI-Stream beat bundle shared by the beam input and the four channel outputs.
interface axis_beam_splitter_if #(
  parameter int DATA_WIDTH = 128
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_beam_splitter.sv
// Fans one beam stream out to four antenna channels, each weighted by its own
// complex Q1.7 coefficient, with a broadcast handshake across enabled channels.
module axis_beam_splitter #(
  parameter int DATA_WIDTH   = 128,
  parameter int SAMPLE_WIDTH = 16,
  parameter int WEIGHT_WIDTH = 8
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic signed [WEIGHT_WIDTH-1:0] bWeight00_real,
  input  logic signed [WEIGHT_WIDTH-1:0] bWeight00_imag,
  input  logic signed [WEIGHT_WIDTH-1:0] bWeight01_real,
  input  logic signed [WEIGHT_WIDTH-1:0] bWeight01_imag,
  input  logic signed [WEIGHT_WIDTH-1:0] bWeight20_real,
  input  logic signed [WEIGHT_WIDTH-1:0] bWeight20_imag,
  input  logic signed [WEIGHT_WIDTH-1:0] bWeight21_real,
  input  logic signed [WEIGHT_WIDTH-1:0] bWeight21_imag,
  input  logic [3:0]                     ch_enable,
  axis_beam_splitter_if.slave            s_axis,
  axis_beam_splitter_if.master           m00_axis,
  axis_beam_splitter_if.master           m01_axis,
  axis_beam_splitter_if.master           m20_axis,
  axis_beam_splitter_if.master           m21_axis,
  output logic                           sat_flag
);
  localparam int NCH   = 4;
  localparam int NSAMP = DATA_WIDTH / (2 * SAMPLE_WIDTH);
  localparam int PW    = SAMPLE_WIDTH + WEIGHT_WIDTH;
  localparam int AW    = PW + 1;
  localparam logic signed [AW-1:0] RND  = AW'(2 ** (WEIGHT_WIDTH - 2));
  localparam logic signed [AW-1:0] SMAX = AW'(2 ** (SAMPLE_WIDTH - 1) - 1);
  localparam logic signed [AW-1:0] SMIN = ~SMAX;

  logic signed [WEIGHT_WIDTH-1:0] w_re [NCH];
  logic signed [WEIGHT_WIDTH-1:0] w_im [NCH];

  assign w_re[0] = bWeight00_real;
  assign w_im[0] = bWeight00_imag;
  assign w_re[1] = bWeight01_real;
  assign w_im[1] = bWeight01_imag;
  assign w_re[2] = bWeight20_real;
  assign w_im[2] = bWeight20_imag;
  assign w_re[3] = bWeight21_real;
  assign w_im[3] = bWeight21_imag;

  // Stage P: raw beat plus the per-packet weight/enable snapshot.
  logic                           p_valid_reg;
  logic                           p_last_reg;
  logic [DATA_WIDTH-1:0]          p_data_reg;
  logic                           sop_reg;
  logic signed [WEIGHT_WIDTH-1:0] snap_re_reg [NCH];
  logic signed [WEIGHT_WIDTH-1:0] snap_im_reg [NCH];
  logic [NCH-1:0]                 snap_en_reg;

  logic                           o_valid_reg;
  logic                           o_last_reg;
  logic [DATA_WIDTH-1:0]          o_data_reg [NCH];
  logic [NCH-1:0]                 pending_reg;
  logic                           sat_reg;

  logic [DATA_WIDTH-1:0]          calc_data [NCH];
  logic [2*NSAMP-1:0]             calc_sat  [NCH];
  logic [NCH-1:0]                 sat_any;
  logic [NCH-1:0]                 m_valid;
  logic [NCH-1:0]                 m_ready;
  logic [NCH-1:0]                 handshake;
  logic [NCH-1:0]                 pending_next;
  logic                           o_free;
  logic                           p_adv;
  logic                           accept;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    for (genvar gk = 0; gk < NSAMP; gk++) begin : g_smp
      logic signed [SAMPLE_WIDTH-1:0] xi, xq, out_i, out_q;
      logic signed [PW-1:0]           p_ir, p_qi, p_ii, p_qr;
      logic signed [AW-1:0]           acc_i, acc_q, sh_i, sh_q;
      logic                           sat_i, sat_q;

      assign xi    = p_data_reg[2*SAMPLE_WIDTH*gk +: SAMPLE_WIDTH];
      assign xq    = p_data_reg[2*SAMPLE_WIDTH*gk + SAMPLE_WIDTH +: SAMPLE_WIDTH];
      assign p_ir  = PW'(xi) * PW'(snap_re_reg[gi]);
      assign p_qi  = PW'(xq) * PW'(snap_im_reg[gi]);
      assign p_ii  = PW'(xi) * PW'(snap_im_reg[gi]);
      assign p_qr  = PW'(xq) * PW'(snap_re_reg[gi]);
      assign acc_i = AW'(p_ir) - AW'(p_qi);
      assign acc_q = AW'(p_ii) + AW'(p_qr);
      // Round half toward +inf, then drop the Q1.7 fraction bits.
      assign sh_i  = (acc_i + RND) >>> (WEIGHT_WIDTH - 1);
      assign sh_q  = (acc_q + RND) >>> (WEIGHT_WIDTH - 1);

      always_comb begin
        out_i = sh_i[SAMPLE_WIDTH-1:0];
        sat_i = 1'b0;
        if (sh_i > SMAX) begin
          out_i = SMAX[SAMPLE_WIDTH-1:0];
          sat_i = 1'b1;
        end else if (sh_i < SMIN) begin
          out_i = SMIN[SAMPLE_WIDTH-1:0];
          sat_i = 1'b1;
        end
      end

      always_comb begin
        out_q = sh_q[SAMPLE_WIDTH-1:0];
        sat_q = 1'b0;
        if (sh_q > SMAX) begin
          out_q = SMAX[SAMPLE_WIDTH-1:0];
          sat_q = 1'b1;
        end else if (sh_q < SMIN) begin
          out_q = SMIN[SAMPLE_WIDTH-1:0];
          sat_q = 1'b1;
        end
      end

      assign calc_data[gi][2*SAMPLE_WIDTH*gk +: 2*SAMPLE_WIDTH] = {out_q, out_i};
      assign calc_sat[gi][2*gk +: 2] = {sat_q, sat_i};
    end

    assign sat_any[gi] = snap_en_reg[gi] && (|calc_sat[gi]);
  end

  assign m_ready = {m21_axis.tready, m20_axis.tready, m01_axis.tready, m00_axis.tready};
  assign m_valid = o_valid_reg ? pending_reg : '0;
  assign handshake    = m_valid & m_ready;
  assign pending_next = pending_reg & ~handshake;
  // The last outstanding acceptance frees O in the same cycle.
  assign o_free = !o_valid_reg || (pending_next == '0);
  assign p_adv  = p_valid_reg && o_free;
  assign s_axis.tready = !p_valid_reg || p_adv;
  assign accept = s_axis.tvalid && s_axis.tready;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      p_valid_reg <= 1'b0;
      p_last_reg  <= 1'b0;
      p_data_reg  <= '0;
      sop_reg     <= 1'b1;
      snap_en_reg <= '0;
      o_valid_reg <= 1'b0;
      o_last_reg  <= 1'b0;
      pending_reg <= '0;
      sat_reg     <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        snap_re_reg[c] <= '0;
        snap_im_reg[c] <= '0;
        o_data_reg[c]  <= '0;
      end
    end else begin
      if (accept) begin
        p_valid_reg <= 1'b1;
        p_data_reg  <= s_axis.tdata;
        p_last_reg  <= s_axis.tlast;
        sop_reg     <= s_axis.tlast;
        if (sop_reg) begin
          snap_en_reg <= ch_enable;
          for (int c = 0; c < NCH; c++) begin
            snap_re_reg[c] <= w_re[c];
            snap_im_reg[c] <= w_im[c];
          end
        end
      end else if (p_adv) begin
        p_valid_reg <= 1'b0;
      end

      if (p_adv) begin
        o_valid_reg <= 1'b1;
        o_last_reg  <= p_last_reg;
        pending_reg <= snap_en_reg;
        for (int c = 0; c < NCH; c++) begin
          o_data_reg[c] <= calc_data[c];
        end
        if (|sat_any) begin
          sat_reg <= 1'b1;
        end
      end else if (o_valid_reg) begin
        pending_reg <= pending_next;
        if (pending_next == '0) begin
          o_valid_reg <= 1'b0;
        end
      end
    end
  end

  assign m00_axis.tdata  = o_data_reg[0];
  assign m00_axis.tvalid = m_valid[0];
  assign m00_axis.tlast  = o_last_reg;
  assign m01_axis.tdata  = o_data_reg[1];
  assign m01_axis.tvalid = m_valid[1];
  assign m01_axis.tlast  = o_last_reg;
  assign m20_axis.tdata  = o_data_reg[2];
  assign m20_axis.tvalid = m_valid[2];
  assign m20_axis.tlast  = o_last_reg;
  assign m21_axis.tdata  = o_data_reg[3];
  assign m21_axis.tvalid = m_valid[3];
  assign m21_axis.tlast  = o_last_reg;
  assign sat_flag        = sat_reg;
endmodule

// File: tb/tb_axis_beam_splitter.sv
// Directed bench for axis_beam_splitter: weighting, saturation, back-pressure,
// per-packet weight snapshot and mid-packet reset.
module tb_axis_beam_splitter;
  localparam int DW = 128;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  logic                clock = 1'b0;
  logic                resetn;
  logic signed [7:0]   w_re [4];
  logic signed [7:0]   w_im [4];
  logic [3:0]          ch_enable;
  logic                sat_flag;
  logic [3:0]          rdy;
  logic [DW-1:0]       od [4];
  logic [3:0]          ov;
  logic [3:0]          ol;

  int tests = 0;
  int fails = 0;

  exp_t          expq [4][$];
  logic [DW-1:0] src_d [$];
  logic          src_l [$];

  always #5 clock = ~clock;

  axis_beam_splitter_if #(.DATA_WIDTH(DW)) s_if ();
  axis_beam_splitter_if #(.DATA_WIDTH(DW)) m00_if ();
  axis_beam_splitter_if #(.DATA_WIDTH(DW)) m01_if ();
  axis_beam_splitter_if #(.DATA_WIDTH(DW)) m20_if ();
  axis_beam_splitter_if #(.DATA_WIDTH(DW)) m21_if ();

  axis_beam_splitter dut (
    .clock          (clock),
    .resetn         (resetn),
    .bWeight00_real (w_re[0]),
    .bWeight00_imag (w_im[0]),
    .bWeight01_real (w_re[1]),
    .bWeight01_imag (w_im[1]),
    .bWeight20_real (w_re[2]),
    .bWeight20_imag (w_im[2]),
    .bWeight21_real (w_re[3]),
    .bWeight21_imag (w_im[3]),
    .ch_enable      (ch_enable),
    .s_axis         (s_if),
    .m00_axis       (m00_if),
    .m01_axis       (m01_if),
    .m20_axis       (m20_if),
    .m21_axis       (m21_if),
    .sat_flag       (sat_flag)
  );

  assign m00_if.tready = rdy[0];
  assign m01_if.tready = rdy[1];
  assign m20_if.tready = rdy[2];
  assign m21_if.tready = rdy[3];
  assign od[0] = m00_if.tdata;
  assign od[1] = m01_if.tdata;
  assign od[2] = m20_if.tdata;
  assign od[3] = m21_if.tdata;
  assign ov = {m21_if.tvalid, m20_if.tvalid, m01_if.tvalid, m00_if.tvalid};
  assign ol = {m21_if.tlast, m20_if.tlast, m01_if.tlast, m00_if.tlast};

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_all(input int re, input int im);
    for (int c = 0; c < 4; c++) begin
      w_re[c] = 8'(re);
      w_im[c] = 8'(im);
    end
  endtask

  // Same complex sample replicated into all four lanes.
  function automatic logic [DW-1:0] rep(input int i, input int q);
    logic [DW-1:0] r;
    logic [15:0]   ii;
    logic [15:0]   qq;
    ii = 16'(i);
    qq = 16'(q);
    for (int k = 0; k < 4; k++) r[32*k +: 32] = {qq, ii};
    return r;
  endfunction

  // Beat k with distinct lanes; m=0 raw, m=1 after weight -1.0, m=2 after weight -j.
  function automatic logic [DW-1:0] mk(input int k, input int m);
    logic [DW-1:0] r;
    int i, q, oi, oq;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      i = 100 * k + 7 * j + 1;
      q = 3 * j - 50 * k - 20;
      case (m)
        0:       begin oi = i;  oq = q;  end
        1:       begin oi = -i; oq = -q; end
        default: begin oi = q;  oq = -i; end
      endcase
      r[32*j +: 32] = {oq[15:0], oi[15:0]};
    end
    return r;
  endfunction

  // Streams src_d/src_l and checks each channel against its expected queue.
  // mode 4: channel 21 not ready for cycles 3..6; mode 5: weight change on beat 1.
  task automatic run_stream(input int n, input int mode);
    int   src;
    logic acc;
    logic stalled;
    logic done;
    exp_t e;
    src = 0;
    stalled = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (mode == 4) rdy[3] = !(cyc >= 3 && cyc <= 6);
      if (mode == 5 && src == 1) begin
        set_all(0, -128);
        ch_enable = 4'hF;
      end
      s_if.tvalid = (src < n);
      if (src < n) begin
        s_if.tdata = src_d[src];
        s_if.tlast = src_l[src];
      end
      #1;
      if (src < n && !s_if.tready) stalled = 1'b1;
      if (mode == 5 && src < n) chk("t5_tready", s_if.tready, 1);
      for (int c = 0; c < 4; c++) begin
        if (expq[c].size() == 0) begin
          chk($sformatf("m%0d_idle_valid", c), ov[c], 0);
        end else if (ov[c] && rdy[c]) begin
          e = expq[c].pop_front();
          chk($sformatf("m%0d_data", c), od[c], e.d);
          chk($sformatf("m%0d_last", c), ol[c], e.l);
        end
      end
      acc = s_if.tvalid && s_if.tready;
      tick;
      if (acc) src++;
      done = (src >= n);
      for (int c = 0; c < 4; c++) if (expq[c].size() != 0) done = 1'b0;
      if (done) break;
    end
    rdy = 4'hF;
    s_if.tvalid = 1'b0;
    #1;
    chk("stream_src_done", src, n);
    chk("stream_post_idle", ov, 0);
    for (int c = 0; c < 4; c++) chk($sformatf("m%0d_drained", c), expq[c].size(), 0);
    if (mode == 4) chk("t4_tready_dropped", stalled, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn      = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = '0;
    rdy         = 4'hF;
    ch_enable   = 4'hF;
    set_all(0, 0);
    repeat (3) tick;
    #1;
    chk("rst_valid", ov, 0);
    chk("rst_last", ol, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_data00", od[0], 0);

    // Test 1: weight -1.0 on all channels, latency to N+2
    resetn = 1'b1;
    set_all(-128, 0);
    s_if.tdata  = rep(1000, -500);
    s_if.tlast  = 1'b1;
    s_if.tvalid = 1'b1;
    #1;
    chk("t1_tready", s_if.tready, 1);
    tick;
    s_if.tvalid = 1'b0;
    #1;
    chk("t1_early_valid", ov, 0);
    chk("t1_tready2", s_if.tready, 1);
    tick;
    #1;
    chk("t1_valid", ov, 4'hF);
    chk("t1_last", ol, 4'hF);
    for (int c = 0; c < 4; c++) chk($sformatf("t1_data%0d", c), od[c], rep(-1000, 500));
    tick;
    #1;
    chk("t1_drain", ov, 0);

    // Test 2: channel 20 with weight (64,64)
    w_re[2] = 8'sd64;
    w_im[2] = 8'sd64;
    s_if.tdata  = rep(256, 256);
    s_if.tlast  = 1'b1;
    s_if.tvalid = 1'b1;
    tick;
    s_if.tvalid = 1'b0;
    tick;
    #1;
    chk("t2_valid", ov, 4'hF);
    chk("t2_ch20", od[2], rep(0, 256));
    chk("t2_ch00", od[0], rep(-256, -256));
    chk("t2_ch21", od[3], rep(-256, -256));
    chk("t2_sat", sat_flag, 0);
    tick;

    // Test 3: saturating corner
    set_all(-128, -128);
    s_if.tdata  = rep(-32768, -32768);
    s_if.tlast  = 1'b1;
    s_if.tvalid = 1'b1;
    tick;
    s_if.tvalid = 1'b0;
    tick;
    #1;
    for (int c = 0; c < 4; c++) chk($sformatf("t3_data%0d", c), od[c], rep(0, 32767));
    chk("t3_sat", sat_flag, 1);
    tick;
    #1;
    chk("t3_sat_sticky", sat_flag, 1);

    // Test 4: 8-beat stream with channel 21 stalled
    set_all(-128, 0);
    ch_enable = 4'hF;
    for (int k = 0; k < 8; k++) begin
      src_d.push_back(mk(k, 0));
      src_l.push_back(k == 7);
      for (int c = 0; c < 4; c++) expq[c].push_back('{d: mk(k, 1), l: (k == 7)});
    end
    run_stream(8, 4);
    chk("t4_sat_sticky", sat_flag, 1);

    // Test 5: packet A keeps its start weights/enable, packet B takes the new ones
    src_d.delete();
    src_l.delete();
    set_all(-128, 0);
    ch_enable = 4'b0101;
    for (int k = 10; k < 14; k++) begin
      src_d.push_back(mk(k, 0));
      src_l.push_back(k >= 12);
    end
    for (int k = 10; k < 13; k++) begin
      expq[0].push_back('{d: mk(k, 1), l: (k == 12)});
      expq[2].push_back('{d: mk(k, 1), l: (k == 12)});
    end
    for (int c = 0; c < 4; c++) expq[c].push_back('{d: mk(13, 2), l: 1'b1});
    run_stream(4, 5);

    // Test 6: reset while channel 21 still owes a handshake
    set_all(-128, 0);
    ch_enable   = 4'hF;
    rdy         = 4'b0111;
    s_if.tdata  = mk(20, 0);
    s_if.tlast  = 1'b1;
    s_if.tvalid = 1'b1;
    tick;
    s_if.tvalid = 1'b0;
    tick;
    #1;
    chk("t6_loaded", ov, 4'hF);
    tick;
    #1;
    chk("t6_partial", ov, 4'b1000);
    chk("t6_sat_before", sat_flag, 1);
    resetn = 1'b0;
    tick;
    #1;
    chk("t6_rst_valid", ov, 0);
    chk("t6_rst_sat", sat_flag, 0);
    chk("t6_rst_data21", od[3], 0);
    resetn      = 1'b1;
    rdy         = 4'hF;
    s_if.tdata  = rep(1000, -500);
    s_if.tlast  = 1'b1;
    s_if.tvalid = 1'b1;
    tick;
    s_if.tvalid = 1'b0;
    tick;
    #1;
    chk("t6_new_valid", ov, 4'hF);
    for (int c = 0; c < 4; c++) chk($sformatf("t6_new_data%0d", c), od[c], rep(-1000, 500));
    tick;
    #1;
    chk("t6_no_stale", ov, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axis_beam_splitter.md
Name: axis_beam_splitter

Overview:
- Transmit-side counterpart of the four-channel receive combiner: takes one beam stream and fans it out to four antenna-channel streams (00, 01, 20, 21).
- Each channel gets a complex multiply by its own weight, then rounding and saturation.
- Broadcast handshake: an input beat retires only after all enabled channels have accepted their copy.
- Sits between the beam source and the per-channel DAC/DUC streams.

Parameters:
DATA_WIDTH, 128, tdata width of input and of each output; multiple of 32
SAMPLE_WIDTH, 16, width of I and of Q per complex sample
WEIGHT_WIDTH, 8, signed Q1.7 weight component width
NSAMP, DATA_WIDTH/(2*SAMPLE_WIDTH) = 4, complex samples per beat (derived)

Ports:
clock  in  1  clock
resetn  in  1  reset, synchronous, active-low
bWeight00_real/_imag, bWeight01_real/_imag, bWeight20_real/_imag, bWeight21_real/_imag  in  WEIGHT_WIDTH each  signed Q1.7 complex weight per channel
ch_enable  in  4  bit0=00, bit1=01, bit2=20, bit3=21; a disabled channel never asserts valid
s_axis_tdata  in  DATA_WIDTH  beam samples; sample k at [32k+:32], I low half, Q high half
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  end of packet
mXX_axis_tdata  out  DATA_WIDTH  weighted samples, same packing (XX = 00, 01, 20, 21)
mXX_axis_tvalid  out  1  per-channel valid
mXX_axis_tready  in  1  per-channel ready
mXX_axis_tlast  out  1  copy of input tlast
sat_flag  out  1  sticky: set when any output component saturated

Behaviour:
- Reset (resetn=0 at posedge): all outputs 0; P_valid=0, O_valid=0, pending=0, sop=1, sat_flag=0. Applies mid-packet too: in-flight beats are discarded and no partial handshake is remembered.
- Stage P:
  - holds the accepted raw beat, its tlast, and a weight/enable snapshot.
  - s_axis_tready = !P_valid || P_adv.
  - Accept on s_axis_tvalid && s_axis_tready.
- Snapshot and sop:
  - Weights and ch_enable are sampled only on accepting a beat while sop=1. Later beats of the packet reuse that snapshot.
  - sop is set by accepting a tlast beat and cleared by accepting a non-tlast beat.
  - Weight changes mid-packet have no effect until the next packet.
- Stage O:
  - holds the weighted data for each channel, tlast, and pending[3:0].
  - Loading O sets pending = snapshot enable.
  - mXX_tvalid = O_valid && pending[XX].
  - A handshake on channel XX clears pending[XX].
- O_free = !O_valid || (pending & ~handshake_vector) == 0. Same-cycle last acceptance frees O.
- P_adv = P_valid && O_free. On P_adv, O loads from P.
- An all-zero enable snapshot loads O with pending=0. That beat drains on the next cycle with no output valid; it is dropped silently.
- Latency: accepted at edge N → mXX_tvalid high after edge N+2. Throughput is 1 beat/cycle when all enabled readies are held high.
- Back-pressure:
  - A stalled channel holds all channels' next beats.
  - Channels that already accepted do not re-see the beat: their valid stays low until O reloads.
  - tdata/tlast stay stable while valid is high.
- Arithmetic, per sample per channel, all signed:
  - I' = xI*wR − xI'... precisely: I' = xI*wR − xQ*wI; Q' = xI*wI + xQ*wR.
  - Each product is 24 bits; each sum is 25 bits.
  - Round: add 64, arithmetic shift right 7 (round half toward +inf).
  - Saturate to [−32768, 32767]. Any clamp sets sat_flag, cleared only by reset.
- Weight −128 represents −1.0; 127 represents 0.9921875.

Test Plan:
1. Reset, then x=(1000,−500), all weights (−128,0), enable=4'hF, all readies=1 → all four outputs (−1000,500) after edge N+2; tlast copied; s_axis_tready=1 throughout.
2. Channel 20 weight (64,64), x=(256,256) → channel 20 outputs (0,256); other channels are unaffected by channel 20's weight.
3. x=(−32768,−32768), weights (−128,−128) → I'=0, Q'=32767; sat_flag=1 and remains 1 afterwards.
4. Streaming 8 beats with m21_tready low for cycles 3–6 and other readies high:
   - channels 00/01/20 accept beat k exactly once;
   - pipeline stalls and s_axis_tready drops once P and O are full;
   - all 8 beats appear in order on every channel with no loss or duplication.
5. Packet A (tlast on beat 2) then packet B; weights change during A's beat 1 → A uses its start-of-packet weights on all beats, B uses the new ones. Enable=4'b0101 → only 00 and 20 assert valid.
6. resetn asserted while O holds a partially accepted beat → next cycle all valids 0 and sat_flag 0. After release, a new beat produces correct outputs on all channels.
